// File: rtl/prefix_or_pkg.sv
// ----------------------------------------------------------------------------
// prefix_or_pkg
// Shared definitions for the prefix-OR arbiter slice: default operand and
// select widths, and the controller state encoding.
// ----------------------------------------------------------------------------
package prefix_or_pkg;

    localparam int W  = 27;   // width of each requester's data vector
    localparam int SW = 5;    // width of each requester's select field

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : prefix_or_pkg

// File: rtl/prefix_or_rr_arb.sv
// ----------------------------------------------------------------------------
// prefix_or_rr_arb
// Two-way round-robin grant. A lone request is granted directly; when both
// requesters are pending the pointer decides. After every taken grant the
// pointer moves to the requester that was not served.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (pointer returns to requester 0)
//   req_valid_i  pending requests, bit i for requester i
//   take_i       the grant is being consumed this cycle
//   grant_o      one-hot (or zero) grant, combinational
// ----------------------------------------------------------------------------
module prefix_or_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid_i,
    input  logic       take_i,
    output logic [1:0] grant_o
);

    import prefix_or_pkg::*;

    logic ptr_q;   // 0: requester 0 wins a tie, 1: requester 1 wins a tie

    // Grant selection from the pending requests and the tie-break pointer.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // Pointer update: after granting requester 0 it points at 1 and vice
    // versa, so grant_o[0] is exactly the next pointer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (take_i && (grant_o != 2'b00)) begin
            ptr_q <= grant_o[0];
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule : prefix_or_rr_arb

// File: rtl/prefix_or_arb.sv
// ----------------------------------------------------------------------------
// prefix_or_arb
// Arbitrates between two requesters, captures the winner's operands and
// computes |data[k-1:0] by walking the vector one bit per cycle from bit 0,
// stopping at the first set bit or at the prefix length k (clamped to W).
// The result is held on a valid/ready response port until consumed.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   req_valid[1:0]        pending requests
//   req_ready[1:0]        request accepted this cycle (one-hot or zero)
//   req0_sel, req1_sel    prefix length k per requester
//   req0_data, req1_data  operand vector per requester
//   rsp_valid             result available
//   rsp_ready             consumer accepts result
//   rsp_result            prefix-OR result
//   rsp_id                requester that owns the result
// ----------------------------------------------------------------------------
module prefix_or_arb #(
    parameter int W  = prefix_or_pkg::W,
    parameter int SW = prefix_or_pkg::SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [SW-1:0] req0_sel,
    input  logic [SW-1:0] req1_sel,
    input  logic [W-1:0]  req0_data,
    input  logic [W-1:0]  req1_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_result,
    output logic          rsp_id
);

    import prefix_or_pkg::*;

    // Clamp ceiling in the same width as idx so sel_q == W compares cleanly.
    localparam logic [SW:0] SEL_MAX = (SW+1)'(W);
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    state_e        state_q;
    logic [SW:0]   idx_q;
    logic [SW:0]   sel_q;
    logic          acc_q;
    logic [W-1:0]  data_q;
    logic          id_q;
    logic          armed_q;      // low for the first cycle after reset release
    logic          rsp_valid_q;
    logic          rsp_result_q;
    logic          rsp_id_q;

    logic [1:0]    grant_s;
    logic          take_s;
    logic [SW-1:0] sel_in_s;
    logic [W-1:0]  data_in_s;
    logic [SW:0]   sel_clamp_s;
    logic          scan_bit_s;

    prefix_or_rr_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .take_i      (take_s),
        .grant_o     (grant_s)
    );

    // Accept window: IDLE only, and never in the cycle reset is released.
    always_comb begin
        take_s = 1'b0;
        if (armed_q && (state_q == IDLE)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Ready goes only to the granted requester while accepting.
    always_comb begin
        req_ready = 2'b00;
        if (take_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Operand mux for the winner, with the select clamped to W.
    always_comb begin
        sel_in_s    = req0_sel;
        data_in_s   = req0_data;
        sel_clamp_s = {1'b0, req0_sel};
        if (grant_s[1]) begin
            sel_in_s  = req1_sel;
            data_in_s = req1_data;
        end else begin
            sel_in_s  = req0_sel;
            data_in_s = req0_data;
        end
        if ({1'b0, sel_in_s} > SEL_MAX) begin
            sel_clamp_s = SEL_MAX;
        end else begin
            sel_clamp_s = {1'b0, sel_in_s};
        end
    end

    // Bit under inspection; only consulted while idx_q < sel_q <= W, so bits
    // at or above the prefix length never reach the result.
    assign scan_bit_s = |(data_q & (ONE_W << idx_q));

    // Controller, scan datapath and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            sel_q        <= '0;
            acc_q        <= 1'b0;
            data_q       <= '0;
            id_q         <= 1'b0;
            armed_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (take_s && (grant_s != 2'b00)) begin
                        sel_q   <= sel_clamp_s;
                        data_q  <= data_in_s;
                        id_q    <= grant_s[1];
                        idx_q   <= '0;
                        acc_q   <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx_q == sel_q) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= acc_q;
                        rsp_id_q     <= id_q;
                        state_q      <= RESP;
                    end else if (scan_bit_s) begin
                        acc_q        <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= 1'b1;
                        rsp_id_q     <= id_q;
                        state_q      <= RESP;
                    end else begin
                        idx_q <= idx_q + {{SW{1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        rsp_result_q <= 1'b0;
                        rsp_id_q     <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q  <= 1'b0;
                    rsp_result_q <= 1'b0;
                    rsp_id_q     <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;

endmodule : prefix_or_arb
